tos_unit_mc: RTL
================

Name: tos_unit_mc

Overview:
- Parametrised next-generation top-of-stack unit for the Forth core.
- Merges TOS datapath, ALU and data-memory port into one sequencer.
- Adds over the single-cycle unit:
  - registered TOS for all sources;
  - carry flag;
  - multi-bit shifts and a multiply, both iterative;
  - a variable-latency memory handshake.
- Sits between the decoder (op issue, valid/ready) and the data RAM/IO bus; the parameter stack supplies NOS.

Parameters:
- width, 16, data word width (>=8, power of two).
- daddr_width, 8, data address width; daddr = TOS[daddr_width-1:0].
- sh_width, 4, shift-amount bits; must equal log2(width).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  decoder presents an op
- op_ready  out  1  unit can accept an op this cycle
- op  in  4  operation code (tos_unit_pkg)
- imm  in  width  immediate for OP_IMM
- pstack_top  in  width  NOS (operand / store data / shift amount)
- rstack_top  in  width  return-stack top for OP_RSTK
- TOS  out  width  registered top of stack
- TOS_is_zero  out  1  TOS == 0, combinational from the TOS register
- carry  out  1  carry/borrow flag
- daddr  out  daddr_width  memory address
- dreq  out  1  memory request, held until dack
- dwrite  out  1  qualifies dreq as write
- dD  out  width  write data
- dQ  in  width  read data, valid with dack
- dack  in  1  memory completion, single-cycle pulse

Behaviour:
- Reset values:
  - TOS=0, carry=0.
  - state=IDLE, op_ready=1.
  - dreq=0, dwrite=0, dD=0.
- Handshake:
  - An op is accepted on a posedge with op_valid & op_ready.
  - op_ready = (state==IDLE).
  - Operands pstack_top, imm and rstack_top are sampled at acceptance only. Multi-cycle ops latch them internally.
- Single-cycle ops (TOS written at the accepting edge; carry unchanged unless stated):
  - OP_XOR, OP_OR, OP_AND: NOS op TOS.
  - OP_NOT: ~TOS.
  - OP_ADD: NOS+TOS, carry = bit width.
  - OP_ADC: NOS+TOS+carry, carry updated.
  - OP_SUB: NOS-TOS, carry = borrow.
  - OP_ASR: arithmetic shift right by 1.
  - OP_IMM: imm.
  - OP_RSTK: rstack_top.
  - OP_ZERO: 0.
- OP_SHL / OP_SHR (shift TOS by n = pstack_top[sh_width-1:0]):
  - State SHIFT. Counter is loaded with n and shifts one bit per cycle, logical.
  - Completion: ready again after max(n,1) cycles. n=0 returns to IDLE after 1 cycle with TOS unchanged.
  - carry = last bit shifted out, or 0 if n=0.
- OP_MUL:
  - State MUL. Shift-add over exactly width cycles.
  - TOS = low width bits of NOS*TOS, unsigned.
  - carry = 1 if the high half is non-zero.
- OP_LOAD:
  - State MEM. dreq=1, dwrite=0, daddr latched from TOS at acceptance.
  - On dack: TOS<=dQ, return to IDLE at that edge.
- OP_STORE:
  - State MEM. dreq=1, dwrite=1, daddr = latched TOS, dD = latched NOS.
  - On dack: return to IDLE, TOS unchanged; the decoder performs the pop.
- Memory boundary cases:
  - dack in the same cycle dreq first rises completes that cycle, giving 1-cycle latency.
  - dack while not in MEM is ignored.
  - No timeout.
- Unused/illegal op codes: treated as NOP, TOS and carry hold, 1 cycle.
- While busy, op_valid is ignored and the TOS/carry visible outputs hold their final-result semantics only at completion. Intermediate values may appear on TOS during SHIFT/MUL.
- Reset mid-operation:
  - Immediately returns to IDLE and drops dreq asynchronously.
  - An in-flight memory access is abandoned; a later dack is ignored.
- Arithmetic rules: all widths are width bits, wrap-around modulo 2^width.

Decomposition:
- tos_unit_pkg: 4-bit op codes OP_XOR..OP_STORE, state enum {IDLE, SHIFT, MUL, MEM}.
- Sub-module tos_unit_alu: combinational single-cycle results plus carry-out. The sequencer/datapath stays in tos_unit_mc.

Test Plan:
- Reset then OP_IMM 16'h1234 -> TOS=16'h1234 one edge after acceptance; TOS_is_zero=0; op_ready stays 1.
- Carry chain:
  - TOS=16'hFFFF, NOS=16'h0001, OP_ADD -> TOS=0, carry=1, TOS_is_zero=1.
  - Then OP_ADC with NOS=1, TOS=0 -> TOS=2.
- OP_SHL with TOS=16'h8001, NOS=4:
  - op_ready low for exactly 4 cycles.
  - TOS=16'h0010, carry=0.
  - Repeat with n=0 -> 1 cycle, TOS unchanged.
- OP_MUL with TOS=300, NOS=300:
  - busy exactly 16 cycles.
  - TOS=16'h5F90 (90000 mod 65536), carry=1.
- OP_LOAD with TOS=8'h42, dack after 3 cycles with dQ=16'hBEEF:
  - dreq held 3 cycles, daddr=8'h42, dwrite=0.
  - TOS=16'hBEEF.
  - Repeat with dack in the first cycle -> 1-cycle completion.
- OP_STORE, NOS=16'hA5A5, then reset asserted before dack:
  - dreq drops immediately, op_ready=1, TOS=0.
  - A late dack causes no state change.

Source files
------------

// File: rtl/tos_unit_pkg.sv
// Shared types for the top-of-stack unit.
// Op codes and sequencer states.
package tos_unit_pkg;

    typedef enum logic [3:0] {
        OP_XOR   = 4'd0,
        OP_OR    = 4'd1,
        OP_AND   = 4'd2,
        OP_NOT   = 4'd3,
        OP_ADD   = 4'd4,
        OP_ADC   = 4'd5,
        OP_SUB   = 4'd6,
        OP_ASR   = 4'd7,
        OP_IMM   = 4'd8,
        OP_RSTK  = 4'd9,
        OP_ZERO  = 4'd10,
        OP_SHL   = 4'd11,
        OP_SHR   = 4'd12,
        OP_MUL   = 4'd13,
        OP_LOAD  = 4'd14,
        OP_STORE = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        MEM   = 2'd3
    } state_e;

endpackage

// File: rtl/tos_unit_alu.sv
// Single-cycle ALU for the top-of-stack unit.
// Ports: op, tos, nos, imm, rstk, cin -> res, cout.
// Ops it does not handle return res=tos, cout=cin.
module tos_unit_alu
    import tos_unit_pkg::*;
#(
    parameter int width = 16
) (
    input  logic [3:0]       op,
    input  logic [width-1:0] tos,
    input  logic [width-1:0] nos,
    input  logic [width-1:0] imm,
    input  logic [width-1:0] rstk,
    input  logic             cin,
    output logic [width-1:0] res,
    output logic             cout
);

    logic [width:0] add_s;
    logic [width:0] sub_s;
    logic           add_cin;

    always_comb begin
        add_cin = cin & (op == OP_ADC);
        add_s   = {1'b0, nos} + {1'b0, tos}
                + {{width{1'b0}}, add_cin};
        // Top bit of the wrapped difference is the borrow.
        sub_s   = {1'b0, nos} - {1'b0, tos};
        res     = tos;
        cout    = cin;
        unique case (1'b1)
            (op == OP_XOR):  res = nos ^ tos;
            (op == OP_OR):   res = nos | tos;
            (op == OP_AND):  res = nos & tos;
            (op == OP_NOT):  res = ~tos;
            (op == OP_ADD),
            (op == OP_ADC): begin
                res  = add_s[width-1:0];
                cout = add_s[width];
            end
            (op == OP_SUB): begin
                res  = sub_s[width-1:0];
                cout = sub_s[width];
            end
            (op == OP_ASR):  res = {tos[width-1], tos[width-1:1]};
            (op == OP_IMM):  res = imm;
            (op == OP_RSTK): res = rstk;
            (op == OP_ZERO): res = '0;
            default: ;
        endcase
    end

endmodule

// File: rtl/tos_unit_mc.sv
// Multi-cycle top-of-stack sequencer: TOS, carry, shifts, multiply, memory.
// Ports: clk, reset, op_valid/op_ready, op, imm, pstack_top, rstack_top,
//        TOS, TOS_is_zero, carry, daddr, dreq, dwrite, dD, dQ, dack.
module tos_unit_mc
    import tos_unit_pkg::*;
#(
    parameter int width       = 16,
    parameter int daddr_width = 8,
    parameter int sh_width    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [3:0]             op,
    input  logic [width-1:0]       imm,
    input  logic [width-1:0]       pstack_top,
    input  logic [width-1:0]       rstack_top,
    output logic [width-1:0]       TOS,
    output logic                   TOS_is_zero,
    output logic                   carry,
    output logic [daddr_width-1:0] daddr,
    output logic                   dreq,
    output logic                   dwrite,
    output logic [width-1:0]       dD,
    input  logic [width-1:0]       dQ,
    input  logic                   dack
);

    state_e                state;
    logic [sh_width-1:0]   cnt;
    logic                  sh_left;
    logic [width-1:0]      mcand;
    logic [2*width-1:0]    prod;
    logic [2*width-1:0]    prod_nxt;
    logic [width:0]        psum;
    logic [width-1:0]      alu_res;
    logic                  alu_cout;

    assign op_ready    = (state == IDLE);
    assign TOS_is_zero = (TOS == '0);

    tos_unit_alu #(
        .width(width)
    ) u_alu (
        .op   (op),
        .tos  (TOS),
        .nos  (pstack_top),
        .imm  (imm),
        .rstk (rstack_top),
        .cin  (carry),
        .res  (alu_res),
        .cout (alu_cout)
    );

    // One shift-add step: upper half accumulates, whole product shifts right.
    always_comb begin
        psum     = {1'b0, prod[2*width-1:width]}
                 + {1'b0, (prod[0] ? mcand : {width{1'b0}})};
        prod_nxt = {psum, prod[width-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            TOS     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sh_left <= 1'b0;
            mcand   <= '0;
            prod    <= '0;
            daddr   <= '0;
            dreq    <= 1'b0;
            dwrite  <= 1'b0;
            dD      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_SHL, OP_SHR: begin
                                state   <= SHIFT;
                                cnt     <= pstack_top[sh_width-1:0];
                                sh_left <= (op == OP_SHL);
                                carry   <= 1'b0;
                            end
                            OP_MUL: begin
                                state <= MUL;
                                cnt   <= sh_width'(width - 1);
                                mcand <= pstack_top;
                                prod  <= {{width{1'b0}}, TOS};
                            end
                            OP_LOAD, OP_STORE: begin
                                state  <= MEM;
                                dreq   <= 1'b1;
                                dwrite <= (op == OP_STORE);
                                daddr  <= TOS[daddr_width-1:0];
                                if (op == OP_STORE) begin
                                    dD <= pstack_top;
                                end
                            end
                            default: begin
                                TOS   <= alu_res;
                                carry <= alu_cout;
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    // cnt==0 only for a zero-amount shift: one idle cycle.
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        if (sh_left) begin
                            {carry, TOS} <= {TOS, 1'b0};
                        end else begin
                            {TOS, carry} <= {1'b0, TOS};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == sh_width'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= IDLE;
                        TOS   <= prod_nxt[width-1:0];
                        carry <= |prod_nxt[2*width-1:width];
                    end
                end
                MEM: begin
                    if (dack) begin
                        state  <= IDLE;
                        dreq   <= 1'b0;
                        dwrite <= 1'b0;
                        if (!dwrite) begin
                            TOS <= dQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
